dm_cache_ctrl: RTL and testbench

- Direct-mapped write-back cache controller and initiator for the cache data memory port (index, write-enable, write line, read line; 1-cycle registered read).
- Accepts single CPU word requests, holds tag/valid/dirty state internally, and returns hits from the data memory.
- On a miss, writes back a dirty victim and allocates the line from main memory over a valid/ready request interface.

---
 rtl/dm_cache_ctrl.sv | 190 +++++++++++++++++++
 tb/tb_dm_cache_ctrl.sv | 295 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dm_cache_ctrl.sv
// Direct-mapped write-back cache controller driving a 1-cycle registered-read data memory.
// Define DM_CACHE_STATS_EN to add saturating hit/miss counters (stat_hits, stat_misses).
`timescale 1ns/1ps
module dm_cache_ctrl #(
    parameter int INDEX_W = 10,
    parameter int TAG_W   = 18,
    parameter int LINE_W  = 128
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cpu_req_valid,
    input  logic              cpu_req_rw,
    input  logic [31:0]       cpu_req_addr,
    input  logic [31:0]       cpu_req_data,
    output logic [31:0]       cpu_res_data,
    output logic              cpu_res_ready,
    output logic [INDEX_W-1:0] dmem_index,
    output logic              dmem_we,
    output logic [LINE_W-1:0] dmem_wdata,
    input  logic [LINE_W-1:0] dmem_rdata,
    output logic              mem_req_valid,
    output logic              mem_req_rw,
    output logic [31:0]       mem_req_addr,
    output logic [LINE_W-1:0] mem_req_data,
    input  logic              mem_rsp_ready,
    input  logic [LINE_W-1:0] mem_rsp_data
`ifdef DM_CACHE_STATS_EN
    ,
    output logic [31:0]       stat_hits,
    output logic [31:0]       stat_misses
`endif
);
    localparam int LINES = 1 << INDEX_W;

    typedef enum logic [2:0] {
        StIdle, StRdWait, StLookup, StWriteBack, StAllocate, StFill
    } state_t;

    state_t              r_state;
    logic                r_rw;
    logic [31:2]         r_addr;
    logic [31:0]         r_wdata;
    logic [LINE_W-1:0]   r_line;
    logic [TAG_W-1:0]    r_tag_arr [LINES];
    logic [LINES-1:0]    r_valid;
    logic [LINES-1:0]    r_dirty;

    logic [INDEX_W-1:0]  w_idx;
    logic [TAG_W-1:0]    w_tag;
    logic [1:0]          w_sel;
    logic                w_hit;
    logic                w_unused;

    assign w_idx    = r_addr[4 +: INDEX_W];
    assign w_tag    = r_addr[4 + INDEX_W +: TAG_W];
    assign w_sel    = r_addr[3:2];
    assign w_hit    = r_valid[w_idx] && (r_tag_arr[w_idx] == w_tag);
    assign w_unused = ^cpu_req_addr[1:0];

    function automatic logic [LINE_W-1:0] f_merge(input logic [LINE_W-1:0] line,
                                                  input logic [1:0] sel,
                                                  input logic [31:0] word);
        logic [LINE_W-1:0] res;
        res = line;
        res[32*int'(sel) +: 32] = word;
        return res;
    endfunction

    function automatic logic [31:0] f_word(input logic [LINE_W-1:0] line, input logic [1:0] sel);
        return line[32*int'(sel) +: 32];
    endfunction

    always_ff @(posedge clk) begin
        if (rst) begin
            r_valid <= '0;
            r_dirty <= '0;
        end else if (r_state == StLookup && w_hit && r_rw) begin
            r_dirty[w_idx] <= 1'b1;
        end else if (r_state == StFill) begin
            r_valid[w_idx] <= 1'b1;
            r_dirty[w_idx] <= r_rw;
        end
    end

    always_ff @(posedge clk) begin
        if (r_state == StFill) r_tag_arr[w_idx] <= w_tag;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state       <= StIdle;
            r_rw          <= 1'b0;
            r_addr        <= '0;
            r_wdata       <= '0;
            r_line        <= '0;
            cpu_res_data  <= '0;
            cpu_res_ready <= 1'b0;
            dmem_index    <= '0;
            dmem_we       <= 1'b0;
            dmem_wdata    <= '0;
            mem_req_valid <= 1'b0;
            mem_req_rw    <= 1'b0;
            mem_req_addr  <= '0;
            mem_req_data  <= '0;
        end else begin
            cpu_res_ready <= 1'b0;
            dmem_we       <= 1'b0;
            unique case (r_state)
                StIdle: begin
                    // The ready cycle still carries the old request; skip it.
                    if (cpu_req_valid && !cpu_res_ready) begin
                        r_rw       <= cpu_req_rw;
                        r_addr     <= cpu_req_addr[31:2];
                        r_wdata    <= cpu_req_data;
                        dmem_index <= cpu_req_addr[4 +: INDEX_W];
                        r_state    <= StRdWait;
                    end
                end
                StRdWait: r_state <= StLookup;
                StLookup: begin
                    if (w_hit) begin
                        if (r_rw) begin
                            dmem_we    <= 1'b1;
                            dmem_wdata <= f_merge(dmem_rdata, w_sel, r_wdata);
                        end else begin
                            cpu_res_data <= f_word(dmem_rdata, w_sel);
                        end
                        cpu_res_ready <= 1'b1;
                        r_state       <= StIdle;
                    end else begin
                        mem_req_valid <= 1'b1;
                        if (r_valid[w_idx] && r_dirty[w_idx]) begin
                            mem_req_rw   <= 1'b1;
                            mem_req_addr <= {r_tag_arr[w_idx], w_idx, 4'h0};
                            mem_req_data <= dmem_rdata;
                            r_state      <= StWriteBack;
                        end else begin
                            mem_req_rw   <= 1'b0;
                            mem_req_addr <= {w_tag, w_idx, 4'h0};
                            r_state      <= StAllocate;
                        end
                    end
                end
                StWriteBack: begin
                    if (mem_req_valid && mem_rsp_ready) begin
                        mem_req_valid <= 1'b0;
                        r_state       <= StAllocate;
                    end
                end
                StAllocate: begin
                    if (mem_req_valid && mem_rsp_ready) begin
                        mem_req_valid <= 1'b0;
                        r_line        <= mem_rsp_data;
                        r_state       <= StFill;
                    end else begin
                        mem_req_valid <= 1'b1;
                        mem_req_rw    <= 1'b0;
                        mem_req_addr  <= {w_tag, w_idx, 4'h0};
                    end
                end
                StFill: begin
                    dmem_we       <= 1'b1;
                    dmem_wdata    <= r_rw ? f_merge(r_line, w_sel, r_wdata) : r_line;
                    cpu_res_data  <= f_word(r_line, w_sel);
                    cpu_res_ready <= 1'b1;
                    r_state       <= StIdle;
                end
                default: r_state <= StIdle;
            endcase
        end
    end

`ifdef DM_CACHE_STATS_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            stat_hits   <= '0;
            stat_misses <= '0;
        end else if (r_state == StLookup) begin
            if (w_hit) begin
                if (stat_hits != 32'hFFFF_FFFF) stat_hits <= stat_hits + 32'd1;
            end else begin
                if (stat_misses != 32'hFFFF_FFFF) stat_misses <= stat_misses + 32'd1;
            end
        end
    end
`else
    // Statistics counters are not built in this configuration.
`endif

endmodule

// File: tb/tb_dm_cache_ctrl.sv
// Randomized bench for dm_cache_ctrl: the cache is checked as a transparent word memory,
// with hit/miss and write-back traffic predicted from a tag/valid/dirty model.
`timescale 1ns/1ps
module tb_dm_cache_ctrl;
    localparam int INDEX_W = 10;
    localparam int TAG_W   = 18;
    localparam int LINE_W  = 128;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic              rst;
    logic              cpu_req_valid, cpu_req_rw;
    logic [31:0]       cpu_req_addr, cpu_req_data, cpu_res_data;
    logic              cpu_res_ready;
    logic [INDEX_W-1:0] dmem_index;
    logic              dmem_we;
    logic [LINE_W-1:0] dmem_wdata, dmem_rdata;
    logic              mem_req_valid, mem_req_rw;
    logic [31:0]       mem_req_addr;
    logic [LINE_W-1:0] mem_req_data;
    logic              mem_rsp_ready;
    logic [LINE_W-1:0] mem_rsp_data;
`ifdef DM_CACHE_STATS_EN
    logic [31:0]       stat_hits, stat_misses;
`endif

    dm_cache_ctrl #(.INDEX_W(INDEX_W), .TAG_W(TAG_W), .LINE_W(LINE_W)) dut (
        .clk(clk), .rst(rst),
        .cpu_req_valid(cpu_req_valid), .cpu_req_rw(cpu_req_rw),
        .cpu_req_addr(cpu_req_addr), .cpu_req_data(cpu_req_data),
        .cpu_res_data(cpu_res_data), .cpu_res_ready(cpu_res_ready),
        .dmem_index(dmem_index), .dmem_we(dmem_we),
        .dmem_wdata(dmem_wdata), .dmem_rdata(dmem_rdata),
        .mem_req_valid(mem_req_valid), .mem_req_rw(mem_req_rw),
        .mem_req_addr(mem_req_addr), .mem_req_data(mem_req_data),
        .mem_rsp_ready(mem_rsp_ready), .mem_rsp_data(mem_rsp_data)
`ifdef DM_CACHE_STATS_EN
        , .stat_hits(stat_hits), .stat_misses(stat_misses)
`endif
    );

    // Data memory with a 1-cycle registered read.
    logic [LINE_W-1:0] dmem_mem [1 << INDEX_W];
    always @(posedge clk) begin
        if (dmem_we) dmem_mem[dmem_index] <= dmem_wdata;
        else         dmem_rdata <= dmem_mem[dmem_index];
    end

    typedef struct { logic rw; logic [31:0] addr; logic [127:0] data; } req_t;
    req_t         req_q[$];
    logic [127:0] mainmem [logic [27:0]];
    logic [31:0]  gold    [logic [29:0]];
    logic [17:0]  m_tag   [1024];
    bit           m_valid [1024];
    bit           m_dirty [1024];
    bit           rsp_block = 1'b0;
    bit           hung = 1'b0;
    int           wait_cnt;
    int           n_checks = 0;
    int           n_errors = 0;

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [127:0] init_line(input logic [27:0] la);
        logic [127:0] res;
        for (int k = 0; k < 4; k++) res[32*k +: 32] = ({la, 4'h0} | 32'(k << 2)) * 32'h9E37_79B1;
        return res;
    endfunction

    function automatic logic [127:0] mem_line(input logic [27:0] la);
        return mainmem.exists(la) ? mainmem[la] : init_line(la);
    endfunction

    function automatic logic [31:0] gold_word(input logic [29:0] wa);
        logic [127:0] line;
        if (gold.exists(wa)) return gold[wa];
        line = mem_line(wa[29:2]);
        return line[32*int'(wa[1:0]) +: 32];
    endfunction

    function automatic logic [127:0] gold_line(input logic [27:0] la);
        logic [127:0] res;
        for (int k = 0; k < 4; k++) res[32*k +: 32] = gold_word({la, 2'(k)});
        return res;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 1024; i++) begin
            m_valid[i] = 1'b0;
            m_dirty[i] = 1'b0;
            m_tag[i]   = '0;
        end
        gold.delete();
    endtask

    // Main memory: random response delay, plus stray ready pulses while no request is up.
    initial begin
        mem_rsp_ready = 1'b0;
        mem_rsp_data  = '0;
        wait_cnt      = 0;
        forever begin
            @(negedge clk);
            mem_rsp_ready = 1'b0;
            if (mem_req_valid && !rsp_block && !rst) begin
                if (wait_cnt == 0) begin
                    req_q.push_back('{mem_req_rw, mem_req_addr, mem_req_data});
                    if (mem_req_rw) mainmem[mem_req_addr[31:4]] = mem_req_data;
                    else            mem_rsp_data = mem_line(mem_req_addr[31:4]);
                    mem_rsp_ready = 1'b1;
                    wait_cnt = $urandom_range(0, 3);
                end else begin
                    wait_cnt--;
                end
            end else if (!mem_req_valid && !rsp_block && $urandom_range(0, 7) == 0) begin
                mem_rsp_ready = 1'b1;
                mem_rsp_data  = {$urandom, $urandom, $urandom, $urandom};
            end
        end
    end

    task automatic do_op(input logic rw, input logic [31:0] addr, input logic [31:0] data);
        logic [9:0]   idx;
        logic [17:0]  tag;
        logic         hit, wb;
        int           exp_reqs, edges;
        bit           seen;
        logic [31:0]  exp_rd, exp_wb_addr;
        logic [127:0] exp_wb_data;
        if (hung) return;
        idx         = addr[13:4];
        tag         = addr[31:14];
        hit         = m_valid[idx] && (m_tag[idx] == tag);
        wb          = !hit && m_valid[idx] && m_dirty[idx];
        exp_reqs    = hit ? 0 : (wb ? 2 : 1);
        exp_wb_addr = {m_tag[idx], idx, 4'h0};
        exp_wb_data = gold_line({m_tag[idx], idx});
        exp_rd      = gold_word(addr[31:2]);
        req_q.delete();
        @(negedge clk);
        cpu_req_valid = 1'b1;
        cpu_req_rw    = rw;
        cpu_req_addr  = addr;
        cpu_req_data  = data;
        seen  = 1'b0;
        edges = 0;
        for (int i = 0; i < 200; i++) begin
            @(posedge clk);
            #1;
            edges++;
            if (cpu_res_ready) begin
                seen = 1'b1;
                break;
            end
        end
        check("ready_seen", seen, 1'b1);
        if (!seen) begin
            hung = 1'b1;
            cpu_req_valid = 1'b0;
            return;
        end
        if (!rw) check("rd_data", cpu_res_data, exp_rd);
        // First edge after valid is the acceptance edge.
        if (hit) check("hit_latency", edges - 1, 2);
        check("mem_req_count", req_q.size(), exp_reqs);
        if (!hit && req_q.size() == exp_reqs) begin
            if (wb) begin
                check("wb_rw", req_q[0].rw, 1'b1);
                check("wb_addr", req_q[0].addr, exp_wb_addr);
                check("wb_data", req_q[0].data, exp_wb_data);
            end
            check("fetch_rw", req_q[exp_reqs-1].rw, 1'b0);
            check("fetch_addr", req_q[exp_reqs-1].addr, {tag, idx, 4'h0});
        end
        if (hit) begin
            m_dirty[idx] = m_dirty[idx] | rw;
        end else begin
            m_valid[idx] = 1'b1;
            m_tag[idx]   = tag;
            m_dirty[idx] = rw;
        end
        if (rw) gold[addr[31:2]] = data;
        @(negedge clk);
        cpu_req_valid = 1'b0;
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [31:0] a;
        bit          seen;
        rst           = 1'b1;
        cpu_req_valid = 1'b0;
        cpu_req_rw    = 1'b0;
        cpu_req_addr  = '0;
        cpu_req_data  = '0;
        model_reset();
        mainmem[28'h0000123] = 128'h4444_4444_3333_3333_2222_2222_1111_1111;
        repeat (3) @(posedge clk);
        #1;
        check("rst_res_ready", cpu_res_ready, 1'b0);
        check("rst_res_data", cpu_res_data, 32'h0);
        check("rst_mem_valid", mem_req_valid, 1'b0);
        check("rst_mem_rw", mem_req_rw, 1'b0);
        check("rst_mem_addr", mem_req_addr, 32'h0);
        check("rst_mem_data", mem_req_data, 128'h0);
        check("rst_dmem_we", dmem_we, 1'b0);
        check("rst_dmem_index", dmem_index, 10'h0);
        @(negedge clk);
        rst = 1'b0;

        do_op(1'b0, 32'h0000_1234, 32'h0);
        check("tp_miss_word1", cpu_res_data, 32'h2222_2222);
        do_op(1'b0, 32'h0000_1238, 32'h0);
        check("tp_hit_word2", cpu_res_data, 32'h3333_3333);
        do_op(1'b1, 32'h0000_123C, 32'hDEAD_BEEF);
        check("tp_wr_hit_line", dmem_mem[10'h123],
              128'hDEAD_BEEF_3333_3333_2222_2222_1111_1111);
        do_op(1'b0, 32'h0004_1230, 32'h0);
        check("tp_wb_upper", req_q.size() > 0 ? req_q[0].data[127:96] : 32'h0, 32'hDEAD_BEEF);
        do_op(1'b1, 32'h0000_2344, 32'h1234_5678);
        check("tp_fill_merge", dmem_mem[10'h234], gold_line(28'h0000234));
        do_op(1'b0, 32'h0008_2340, 32'h0);

        for (int n = 0; n < 400; n++) begin
            a = {16'h0, 2'($urandom_range(0, 3)), 10'h3F0 + 10'($urandom_range(0, 3)),
                 4'($urandom)};
            do_op(1'($urandom), a, $urandom);
        end

        // Abort a write-back with reset; the dirty line is dropped.
        do_op(1'b1, 32'h0000_5000, 32'hCAFE_F00D);
        do_op(1'b0, 32'h0000_5000, 32'h0);
        rsp_block = 1'b1;
        @(negedge clk);
        cpu_req_valid = 1'b1;
        cpu_req_rw    = 1'b0;
        cpu_req_addr  = 32'h0000_9000;
        seen = 1'b0;
        for (int i = 0; i < 50; i++) begin
            @(posedge clk);
            #1;
            if (mem_req_valid && mem_req_rw) begin
                seen = 1'b1;
                break;
            end
        end
        check("rst_wb_seen", seen, 1'b1);
        @(negedge clk);
        rst           = 1'b1;
        cpu_req_valid = 1'b0;
        @(posedge clk);
        #1;
        check("rst_abort_valid", mem_req_valid, 1'b0);
        check("rst_abort_ready", cpu_res_ready, 1'b0);
        @(negedge clk);
        rst       = 1'b0;
        rsp_block = 1'b0;
        model_reset();
        do_op(1'b0, 32'h0000_5000, 32'h0);
        check("rst_prior_hit_misses", req_q.size(), 1);

`ifdef DM_CACHE_STATS_EN
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        model_reset();
        do_op(1'b0, 32'h0000_7000, 32'h0);
        do_op(1'b0, 32'h0000_7004, 32'h0);
        do_op(1'b0, 32'h0000_7008, 32'h0);
        do_op(1'b0, 32'h0004_7000, 32'h0);
        check("stat_hits", stat_hits, 32'd2);
        check("stat_misses", stat_misses, 32'd2);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        check("stat_hits_rst", stat_hits, 32'd0);
        check("stat_misses_rst", stat_misses, 32'd0);
        @(negedge clk);
        rst = 1'b0;
`endif

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
